mig_ui_resp: RTL and testbench
==============================

# mig_ui_resp

Synthesizable responder for the MIG-style user interface (app_cmd/app_addr/app_en, app_wdf_*, app_rd_data*) that the traffic generators drive. It stands in for the memory controller in simulation and on-fabric loopback: it accepts write and read commands, stores data in a local RAM, and returns read data in order after a fixed latency. It also generates deterministic back-pressure, calibration-done timing and protocol-error/statistics outputs, so generator-side flow control can be checked without a DDR model.

## Interface
- APP_DATA_WIDTH, 64, data bus width; must be a multiple of 8.
- APP_ADDR_WIDTH, 33, address bus width.
- MEM_DEPTH_LOG2, 10, log2 of RAM depth in APP_DATA_WIDTH words.
- CMD_DEPTH_LOG2, 2, log2 of command FIFO depth.
- WDF_DEPTH_LOG2, 2, log2 of write-data FIFO depth.
- RD_LATENCY, 8, read pipeline stages; must be at least 1.
- CALIB_CYCLES, 16, cycles from reset release to init_calib_complete.
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- app_cmd  in  3  0 = write, 1 = read, other values are illegal.
- app_addr  in  APP_ADDR_WIDTH  byte address.
- app_en  in  1  command valid.
- app_rdy  out  1  command ready.
- app_wdf_data  in  APP_DATA_WIDTH  write data.
- app_wdf_mask  in  APP_DATA_WIDTH/8  per-byte mask; 1 = byte not written.
- app_wdf_wren  in  1  write data valid.
- app_wdf_end  in  1  last beat; must equal app_wdf_wren.
- app_wdf_rdy  out  1  write-data ready.
- app_rd_data  out  APP_DATA_WIDTH  read data.
- app_rd_data_valid  out  1  read data valid, one cycle per read.
- init_calib_complete  out  1  interface usable.
- bp_en  in  1  enables periodic app_rdy back-pressure.
- proto_err  out  1  sticky protocol error.
- wr_count  out  16  committed writes; wraps modulo 2^16.
- rd_count  out  16  returned reads; wraps modulo 2^16.

## Operation
- **Reset (rst low).** All outputs are 0. FIFOs, read pipeline, calibration counter and free-running counter are cleared. RAM contents are not reset and are undefined until written. Asserting rst mid-operation discards every queued command, queued write beat and in-flight read; app_rd_data_valid drops asynchronously.
- **Calibration.** init_calib_complete rises CALIB_CYCLES cycles after rst deasserts and stays high. Until then app_rdy = app_wdf_rdy = 0.
- **Command accept.** A command is accepted on an edge where app_en && app_rdy.
  - cmd 0 or 1: pushed, with app_addr, into one in-order command FIFO.
  - Any other cmd: dropped and proto_err set.
- **app_rdy** = calib && !cmd_full && !(bp_en && cnt[1:0]==3), where cnt is a 2-bit free-running counter. It is built from registered state only, so a FIFO pop does not open a slot in the same cycle.
- **Write data.** A beat is accepted when app_wdf_wren && app_wdf_rdy and pushed (data+mask) into the write-data FIFO. app_wdf_rdy = calib && !wdf_full. A beat with app_wdf_wren && !app_wdf_end sets proto_err but is still accepted. Data may arrive before, with, or after its command.
- **Execution.** One head command per cycle, strictly in order.
  - Write at head: commits only when the wdf FIFO is non-empty; pops both FIFOs and writes unmasked bytes to RAM[word]. wr_count++.
  - Write at head with wdf FIFO empty: blocks the head; later reads wait behind it.
  - Read at head: pops, reads RAM[word], and enters the RD_LATENCY-stage pipeline.
  - word = app_addr[MEM_DEPTH_LOG2+2:3]. Higher address bits are ignored, so addresses alias modulo 8·2^MEM_DEPTH_LOG2. Bits [2:0] are ignored.
- **Read return.** Read data leaves the pipeline in order. app_rd_data_valid pulses once per read and rd_count++. There is no back-pressure on read return. app_rd_data holds its last value when valid is low.
- **Hazards.** A read always returns data including every write committed before it in command order. Same-cycle RAM write and read to the same word cannot occur because only one head command executes per cycle.
- **proto_err** clears only on reset.

## Timing
- Command accepted at edge T: earliest execution at edge T+1.
- Read executed at edge E: app_rd_data_valid is high after edge E+RD_LATENCY. Minimum accept-to-valid latency is RD_LATENCY+1 cycles.
- Write accepted at T with data already present or accepted at T: commits at T+1. A read accepted at T returns the new data.
- Throughput: one command per cycle sustained when bp_en = 0 and no write waits for data.
- With bp_en = 1: app_rdy is low exactly one cycle in four after calibration, provided the FIFO is not full.
- Full FIFO: app_rdy/app_wdf_rdy are low the cycle after the push that fills it, and high the cycle after the first pop.

## Test plan
- **Reset and calibration:** release rst, hold app_en = 0 → init_calib_complete rises at cycle 16; app_rdy and app_wdf_rdy rise with it; all other outputs remain 0.
- **Write/read-back:** 16 writes of data 0x100000·k to addresses 0x0+8k, each with matching wdf beat, then 16 reads → 16 valid pulses in address order with matching data; wr_count = rd_count = 16; first valid 9 cycles after the first read is accepted.
- **Data-after-command:** write to 0x40 with data delayed 5 cycles, then immediately a read of 0x40 → read blocks; valid returns the delayed data; no reordering.
- **Back-pressure and full:** bp_en = 1, app_en held high with reads → app_rdy pattern 1,1,1,0 repeating. With writes and wdf held off → app_rdy low after 4 accepts.
- **Mask and aliasing:** write 0xFFFF…FF to 0x0, then 0x0 with mask 0xF0 to address 0x2000 (aliases word 0) → read of 0x0 returns 0xFFFFFFFF00000000.
- **Errors and mid-run reset:** app_cmd = 2 → proto_err = 1, command ignored. Assert rst while 3 reads are in flight → valid drops immediately, no late pulses after release, counts = 0.

Source files
------------

// File: rtl/mig_ui_resp.sv
// mig_ui_resp -- MIG-style user-interface responder.
//
// Stands in for a DDR memory controller. Write/read commands go into one
// in-order command FIFO. Write beats go into a separate write-data FIFO.
// Commands execute against a local RAM, one head command per cycle. Read
// data returns in order after a fixed pipeline latency. The block also
// models calibration delay, periodic back-pressure, a sticky protocol
// error flag and write/read statistics.
//
// Ports:
//   clk                  single clock, rising edge
//   rst                  asynchronous reset, active low
//   app_cmd/addr/en      command channel (0 = write, 1 = read), app_rdy ready
//   app_wdf_data/mask    write beat (mask bit 1 = byte not written)
//   app_wdf_wren/end     beat valid / last beat, app_wdf_rdy ready
//   app_rd_data[_valid]  read return, one valid pulse per read, no stall
//   init_calib_complete  interface usable
//   bp_en                enables app_rdy low one cycle in four
//   proto_err            sticky: illegal command or wren without end
//   wr_count/rd_count    committed writes / returned reads, mod 2^16
module mig_ui_resp #(
    parameter int unsigned APP_DATA_WIDTH = 64,
    parameter int unsigned APP_ADDR_WIDTH = 33,
    parameter int unsigned MEM_DEPTH_LOG2 = 10,
    parameter int unsigned CMD_DEPTH_LOG2 = 2,
    parameter int unsigned WDF_DEPTH_LOG2 = 2,
    parameter int unsigned RD_LATENCY     = 8,
    parameter int unsigned CALIB_CYCLES   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [2:0]                  app_cmd,
    input  logic [APP_ADDR_WIDTH-1:0]   app_addr,
    input  logic                        app_en,
    output logic                        app_rdy,
    input  logic [APP_DATA_WIDTH-1:0]   app_wdf_data,
    input  logic [APP_DATA_WIDTH/8-1:0] app_wdf_mask,
    input  logic                        app_wdf_wren,
    input  logic                        app_wdf_end,
    output logic                        app_wdf_rdy,
    output logic [APP_DATA_WIDTH-1:0]   app_rd_data,
    output logic                        app_rd_data_valid,
    output logic                        init_calib_complete,
    input  logic                        bp_en,
    output logic                        proto_err,
    output logic [15:0]                 wr_count,
    output logic [15:0]                 rd_count
);

    localparam int unsigned MASK_W    = APP_DATA_WIDTH / 8;
    localparam int unsigned MEM_DEPTH = 1 << MEM_DEPTH_LOG2;
    localparam int unsigned CMD_DEPTH = 1 << CMD_DEPTH_LOG2;
    localparam int unsigned WDF_DEPTH = 1 << WDF_DEPTH_LOG2;
    localparam int unsigned CAL_W     = $clog2(CALIB_CYCLES + 1);

    localparam logic [CMD_DEPTH_LOG2:0]   CMD_CNT_ONE = 1;
    localparam logic [WDF_DEPTH_LOG2:0]   WDF_CNT_ONE = 1;
    localparam logic [CMD_DEPTH_LOG2-1:0] CMD_PTR_ONE = 1;
    localparam logic [WDF_DEPTH_LOG2-1:0] WDF_PTR_ONE = 1;
    localparam logic [CAL_W-1:0]          CAL_ONE     = 1;
    localparam logic [CAL_W-1:0]          CAL_LAST    = CAL_W'(CALIB_CYCLES - 1);

    // Calibration and back-pressure phase
    logic [CAL_W-1:0] cal_cnt;
    logic [1:0]       bp_cnt;

    // Command FIFO: read flag + RAM word index
    logic                      cmd_is_rd [CMD_DEPTH];
    logic [MEM_DEPTH_LOG2-1:0] cmd_word  [CMD_DEPTH];
    logic [CMD_DEPTH_LOG2-1:0] cmd_wp, cmd_rp;
    logic [CMD_DEPTH_LOG2:0]   cmd_cnt;

    // Write-data FIFO
    logic [APP_DATA_WIDTH-1:0] wdf_data [WDF_DEPTH];
    logic [MASK_W-1:0]         wdf_mask [WDF_DEPTH];
    logic [WDF_DEPTH_LOG2-1:0] wdf_wp, wdf_rp;
    logic [WDF_DEPTH_LOG2:0]   wdf_cnt;

    // RAM and read pipeline
    logic [APP_DATA_WIDTH-1:0] mem      [MEM_DEPTH];
    logic [APP_DATA_WIDTH-1:0] rd_dpipe [RD_LATENCY];
    logic [RD_LATENCY-1:0]     rd_vpipe;

    logic                      cmd_acc, cmd_push, cmd_bad;
    logic                      wdf_push, wdf_bad;
    logic                      head_valid, head_rd, wr_commit, rd_exec, cmd_pop;
    logic [MEM_DEPTH_LOG2-1:0] head_word, in_word;
    logic                      unused_addr_bits;

    always_comb begin
        // Counts are registered, and a count reaches its MSB only when the
        // FIFO is full, so a same-cycle pop never opens a slot.
        app_rdy     = init_calib_complete && !cmd_cnt[CMD_DEPTH_LOG2]
                      && !(bp_en && (bp_cnt == 2'd3));
        app_wdf_rdy = init_calib_complete && !wdf_cnt[WDF_DEPTH_LOG2];

        in_word          = app_addr[MEM_DEPTH_LOG2+2:3];
        unused_addr_bits = ^{app_addr[APP_ADDR_WIDTH-1:MEM_DEPTH_LOG2+3], app_addr[2:0]};

        cmd_acc  = app_en && app_rdy;
        cmd_push = cmd_acc && (app_cmd[2:1] == 2'b00);
        cmd_bad  = cmd_acc && (app_cmd[2:1] != 2'b00);
        wdf_push = app_wdf_wren && app_wdf_rdy;
        wdf_bad  = wdf_push && !app_wdf_end;

        head_valid = (cmd_cnt != '0);
        head_rd    = cmd_is_rd[cmd_rp];
        head_word  = cmd_word[cmd_rp];
        // A head write waits for its beat, stalling everything behind it.
        wr_commit  = head_valid && !head_rd && (wdf_cnt != '0);
        rd_exec    = head_valid && head_rd;
        cmd_pop    = wr_commit || rd_exec;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cal_cnt             <= '0;
            init_calib_complete <= 1'b0;
            bp_cnt              <= '0;
            cmd_wp              <= '0;
            cmd_rp              <= '0;
            cmd_cnt             <= '0;
            wdf_wp              <= '0;
            wdf_rp              <= '0;
            wdf_cnt             <= '0;
            rd_vpipe            <= '0;
            app_rd_data_valid   <= 1'b0;
            app_rd_data         <= '0;
            proto_err           <= 1'b0;
            wr_count            <= '0;
            rd_count            <= '0;
        end else begin
            bp_cnt <= bp_cnt + 2'd1;

            if (!init_calib_complete) begin
                cal_cnt <= cal_cnt + CAL_ONE;
                if (cal_cnt == CAL_LAST) begin
                    init_calib_complete <= 1'b1;
                end
            end

            if (cmd_push) cmd_wp <= cmd_wp + CMD_PTR_ONE;
            if (cmd_pop)  cmd_rp <= cmd_rp + CMD_PTR_ONE;
            if (cmd_push && !cmd_pop) begin
                cmd_cnt <= cmd_cnt + CMD_CNT_ONE;
            end else if (!cmd_push && cmd_pop) begin
                cmd_cnt <= cmd_cnt - CMD_CNT_ONE;
            end

            if (wdf_push)  wdf_wp <= wdf_wp + WDF_PTR_ONE;
            if (wr_commit) wdf_rp <= wdf_rp + WDF_PTR_ONE;
            if (wdf_push && !wr_commit) begin
                wdf_cnt <= wdf_cnt + WDF_CNT_ONE;
            end else if (!wdf_push && wr_commit) begin
                wdf_cnt <= wdf_cnt - WDF_CNT_ONE;
            end

            rd_vpipe[0] <= rd_exec;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                rd_vpipe[i] <= rd_vpipe[i-1];
            end

            app_rd_data_valid <= rd_vpipe[RD_LATENCY-1];
            if (rd_vpipe[RD_LATENCY-1]) begin
                app_rd_data <= rd_dpipe[RD_LATENCY-1];
                rd_count    <= rd_count + 16'd1;
            end

            if (wr_commit) wr_count <= wr_count + 16'd1;
            if (cmd_bad || wdf_bad) proto_err <= 1'b1;
        end
    end

    // FIFO storage: validity is carried by the pointers, so no reset needed.
    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_is_rd[cmd_wp] <= app_cmd[0];
            cmd_word[cmd_wp]  <= in_word;
        end
        if (wdf_push) begin
            wdf_data[wdf_wp] <= app_wdf_data;
            wdf_mask[wdf_wp] <= app_wdf_mask;
        end
    end

    // RAM with byte-masked write and registered read. A write commits one
    // edge before any later read can execute, so the read sees it.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            for (int unsigned b = 0; b < MASK_W; b++) begin
                if (!wdf_mask[wdf_rp][b]) begin
                    mem[head_word][8*b +: 8] <= wdf_data[wdf_rp][8*b +: 8];
                end
            end
        end
        if (rd_exec) begin
            rd_dpipe[0] <= mem[head_word];
        end
        for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            rd_dpipe[i] <= rd_dpipe[i-1];
        end
    end

endmodule

// File: tb/tb_mig_ui_resp.sv
module tb_mig_ui_resp;

    localparam int DW = 64;
    localparam int AW = 33;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      app_cmd;
    logic [AW-1:0]   app_addr;
    logic            app_en;
    logic            app_rdy;
    logic [DW-1:0]   app_wdf_data;
    logic [DW/8-1:0] app_wdf_mask;
    logic            app_wdf_wren;
    logic            app_wdf_end;
    logic            app_wdf_rdy;
    logic [DW-1:0]   app_rd_data;
    logic            app_rd_data_valid;
    logic            init_calib_complete;
    logic            bp_en;
    logic            proto_err;
    logic [15:0]     wr_count;
    logic [15:0]     rd_count;

    int n_cmp   = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int acc_cyc = 0;

    logic [DW-1:0] rq[$];
    int            rc[$];

    mig_ui_resp #(
        .APP_DATA_WIDTH(DW),
        .APP_ADDR_WIDTH(AW),
        .MEM_DEPTH_LOG2(10),
        .CMD_DEPTH_LOG2(2),
        .WDF_DEPTH_LOG2(2),
        .RD_LATENCY(8),
        .CALIB_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .app_cmd(app_cmd),
        .app_addr(app_addr),
        .app_en(app_en),
        .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data),
        .app_wdf_mask(app_wdf_mask),
        .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end),
        .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data),
        .app_rd_data_valid(app_rd_data_valid),
        .init_calib_complete(init_calib_complete),
        .bp_en(bp_en),
        .proto_err(proto_err),
        .wr_count(wr_count),
        .rd_count(rd_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture read returns with the edge number they appeared after.
    always @(negedge clk) begin
        if (app_rd_data_valid === 1'b1) begin
            rq.push_back(app_rd_data);
            rc.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command and/or write beat; each side is dropped once accepted.
    task automatic xfer(input bit dc, input bit dd, input logic [2:0] c,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW/8-1:0] m, input bit e);
        bit c_ok;
        bit d_ok;
        app_en       = dc;
        app_cmd      = c;
        app_addr     = a;
        app_wdf_wren = dd;
        app_wdf_end  = dd & e;
        app_wdf_data = d;
        app_wdf_mask = m;
        for (int i = 0; i < 64 && (app_en || app_wdf_wren); i++) begin
            c_ok = app_en && app_rdy;
            d_ok = app_wdf_wren && app_wdf_rdy;
            tick();
            if (c_ok || d_ok) acc_cyc = cyc;
            if (c_ok) app_en = 1'b0;
            if (d_ok) begin
                app_wdf_wren = 1'b0;
                app_wdf_end  = 1'b0;
            end
        end
        n_cmp++;
        if (app_en || app_wdf_wren) begin
            n_bad++;
            $display("FAIL xfer_accept: pending cmd=%0b data=%0b, required both accepted in 64 cycles",
                     app_en, app_wdf_wren);
            app_en       = 1'b0;
            app_wdf_wren = 1'b0;
            app_wdf_end  = 1'b0;
        end
    endtask

    task automatic wait_reads(input int n);
        for (int i = 0; i < 100 && rq.size() < n; i++) tick();
        n_cmp++;
        if (rq.size() != n) begin
            n_bad++;
            $display("FAIL read_returns: got %0d, required %0d", rq.size(), n);
        end
    endtask

    task automatic test_reset();
        logic exp;
        rst = 1'b1; bp_en = 1'b0; app_en = 1'b0; app_cmd = '0; app_addr = '0;
        app_wdf_wren = 1'b0; app_wdf_end = 1'b0; app_wdf_data = '0; app_wdf_mask = '0;
        #2 rst = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({app_rdy, app_wdf_rdy, app_rd_data_valid, init_calib_complete, proto_err} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b required 00000",
                     {app_rdy, app_wdf_rdy, app_rd_data_valid, init_calib_complete, proto_err});
        end
        n_cmp++;
        if ({wr_count, rd_count, app_rd_data} !== 96'b0) begin
            n_bad++;
            $display("FAIL reset_values: got wr=%h rd=%h data=%h required all 0", wr_count, rd_count, app_rd_data);
        end
        rst = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp = (k >= 16);
            n_cmp++;
            if ({init_calib_complete, app_rdy, app_wdf_rdy} !== {3{exp}}) begin
                n_bad++;
                $display("FAIL calib_cycle_%0d: calib/rdy/wdf_rdy got %b required %b",
                         k, {init_calib_complete, app_rdy, app_wdf_rdy}, {3{exp}});
            end
        end
        n_cmp++;
        if ({proto_err, app_rd_data_valid, wr_count, rd_count} !== 34'b0) begin
            n_bad++;
            $display("FAIL calib_idle: err=%b valid=%b wr=%0d rd=%0d required all 0",
                     proto_err, app_rd_data_valid, wr_count, rd_count);
        end
    endtask

    task automatic test_write_read();
        int first = 0;
        rq.delete(); rc.delete();
        for (int k = 0; k < 16; k++) xfer(1, 1, 3'd0, AW'(8 * k), 64'h10_0000 * 64'(k), '0, 1);
        for (int k = 0; k < 16; k++) begin
            xfer(1, 0, 3'd1, AW'(8 * k), '0, '0, 1);
            if (k == 0) first = acc_cyc;
        end
        wait_reads(16);
        if (rq.size() == 16) begin
            for (int k = 0; k < 16; k++) begin
                n_cmp++;
                if (rq[k] !== 64'h10_0000 * 64'(k)) begin
                    n_bad++;
                    $display("FAIL wr_rd_data_%0d: got %h required %h", k, rq[k], 64'h10_0000 * 64'(k));
                end
            end
            n_cmp++;
            if (rc[0] - first != 9) begin
                n_bad++;
                $display("FAIL first_read_latency: got %0d required 9", rc[0] - first);
            end
            n_cmp++;
            if (rc[15] - rc[0] != 15) begin
                n_bad++;
                $display("FAIL read_back_to_back: span got %0d required 15", rc[15] - rc[0]);
            end
        end
        n_cmp++;
        if (wr_count !== 16'd16 || rd_count !== 16'd16) begin
            n_bad++;
            $display("FAIL wr_rd_counts: got wr=%0d rd=%0d required 16/16", wr_count, rd_count);
        end
    endtask

    task automatic test_data_after_cmd();
        int td;
        rq.delete(); rc.delete();
        xfer(1, 0, 3'd0, 33'h40, '0, '0, 1);
        xfer(1, 0, 3'd1, 33'h40, '0, '0, 1);
        repeat (5) tick();
        n_cmp++;
        if (rq.size() != 0 || wr_count !== 16'd16) begin
            n_bad++;
            $display("FAIL blocked_write: returns=%0d wr=%0d required 0/16", rq.size(), wr_count);
        end
        xfer(0, 1, 3'd0, '0, 64'hDEAD_BEEF_0123_4567, '0, 1);
        td = acc_cyc;
        wait_reads(1);
        if (rq.size() == 1) begin
            n_cmp++;
            if (rq[0] !== 64'hDEAD_BEEF_0123_4567) begin
                n_bad++;
                $display("FAIL late_data_value: got %h required deadbeef01234567", rq[0]);
            end
            n_cmp++;
            if (rc[0] - td != 10) begin
                n_bad++;
                $display("FAIL late_data_latency: got %0d required 10", rc[0] - td);
            end
        end
        repeat (12) tick();
        n_cmp++;
        if (rq.size() != 1 || wr_count !== 16'd17 || rd_count !== 16'd17) begin
            n_bad++;
            $display("FAIL late_data_counts: returns=%0d wr=%0d rd=%0d required 1/17/17",
                     rq.size(), wr_count, rd_count);
        end
    endtask

    task automatic test_backpressure();
        logic [11:0] s;
        logic [11:0] e;
        logic [5:0]  f;
        int z = -1;
        int acc = 0;
        rq.delete(); rc.delete();
        bp_en = 1'b1; app_en = 1'b1; app_cmd = 3'd1; app_addr = '0;
        for (int i = 0; i < 12; i++) begin
            s[i] = app_rdy;
            if (app_rdy) acc++;
            tick();
        end
        app_en = 1'b0; bp_en = 1'b0;
        for (int i = 3; i >= 0; i--) if (!s[i]) z = i;
        if (z < 0) z = 0;
        for (int i = 0; i < 12; i++) e[i] = ((i % 4) != z);
        n_cmp++;
        if (s !== e) begin
            n_bad++;
            $display("FAIL bp_pattern: got %b required %b", s, e);
        end
        n_cmp++;
        if (acc != 9) begin
            n_bad++;
            $display("FAIL bp_accepts: got %0d required 9", acc);
        end
        wait_reads(9);
        n_cmp++;
        if (rd_count !== 16'd26) begin
            n_bad++;
            $display("FAIL bp_rd_count: got %0d required 26", rd_count);
        end

        // Writes with no data: command FIFO fills after 4 accepts.
        app_en = 1'b1; app_cmd = 3'd0; app_addr = 33'h80;
        for (int i = 0; i < 6; i++) begin
            f[i] = app_rdy;
            tick();
        end
        app_en = 1'b0;
        n_cmp++;
        if (f !== 6'b001111) begin
            n_bad++;
            $display("FAIL cmd_full_pattern: got %b required 001111", f);
        end
        xfer(0, 1, 3'd0, '0, 64'hA1, '0, 1);
        n_cmp++;
        if (app_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL full_before_pop: app_rdy got %b required 0", app_rdy);
        end
        tick();
        n_cmp++;
        if (app_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL full_after_pop: app_rdy got %b required 1", app_rdy);
        end
        xfer(0, 1, 3'd0, '0, 64'hA2, '0, 1);
        xfer(0, 1, 3'd0, '0, 64'hA3, '0, 1);
        xfer(0, 1, 3'd0, '0, 64'hA4, '0, 1);
        repeat (4) tick();
        n_cmp++;
        if (wr_count !== 16'd21) begin
            n_bad++;
            $display("FAIL full_wr_count: got %0d required 21", wr_count);
        end
        rq.delete(); rc.delete();
        xfer(1, 0, 3'd1, 33'h80, '0, '0, 1);
        wait_reads(1);
        n_cmp++;
        if (rq.size() != 1 || rq[0] !== 64'hA4) begin
            n_bad++;
            $display("FAIL full_last_write: got %h required a4", app_rd_data);
        end
    endtask

    task automatic test_mask_alias();
        rq.delete(); rc.delete();
        xfer(1, 1, 3'd0, 33'h0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1);
        xfer(1, 1, 3'd0, 33'h2000, 64'h0, 8'hF0, 1);
        xfer(1, 0, 3'd1, 33'h0, '0, '0, 1);
        wait_reads(1);
        n_cmp++;
        if (rq.size() != 1 || rq[0] !== 64'hFFFF_FFFF_0000_0000) begin
            n_bad++;
            $display("FAIL mask_alias: got %h required ffffffff00000000", app_rd_data);
        end
        n_cmp++;
        if (wr_count !== 16'd23 || rd_count !== 16'd28) begin
            n_bad++;
            $display("FAIL mask_counts: got wr=%0d rd=%0d required 23/28", wr_count, rd_count);
        end
    endtask

    task automatic test_errors_reset();
        n_cmp++;
        if (proto_err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clean: proto_err got %b required 0", proto_err);
        end
        rq.delete(); rc.delete();
        xfer(1, 0, 3'd2, 33'h0, '0, '0, 1);
        tick();
        n_cmp++;
        if (proto_err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_bad_cmd: proto_err got %b required 1", proto_err);
        end
        repeat (12) tick();
        n_cmp++;
        if (rq.size() != 0 || wr_count !== 16'd23 || rd_count !== 16'd28) begin
            n_bad++;
            $display("FAIL err_cmd_ignored: returns=%0d wr=%0d rd=%0d required 0/23/28",
                     rq.size(), wr_count, rd_count);
        end

        xfer(1, 0, 3'd1, 33'h0, '0, '0, 1);
        xfer(1, 0, 3'd1, 33'h8, '0, '0, 1);
        xfer(1, 0, 3'd1, 33'h10, '0, '0, 1);
        for (int i = 0; i < 30 && !app_rd_data_valid; i++) tick();
        n_cmp++;
        if (app_rd_data_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL inflight_valid: got %b required 1", app_rd_data_valid);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({app_rd_data_valid, init_calib_complete, app_rdy, app_wdf_rdy, proto_err} !== 5'b0 ||
            wr_count !== 16'd0 || rd_count !== 16'd0) begin
            n_bad++;
            $display("FAIL async_reset: flags=%b wr=%0d rd=%0d required 0",
                     {app_rd_data_valid, init_calib_complete, app_rdy, app_wdf_rdy, proto_err},
                     wr_count, rd_count);
        end
        tick();
        tick();
        rst = 1'b1;
        repeat (30) tick();
        n_cmp++;
        if (rq.size() != 0 || rd_count !== 16'd0 || wr_count !== 16'd0 || init_calib_complete !== 1'b1) begin
            n_bad++;
            $display("FAIL post_reset: returns=%0d rd=%0d wr=%0d calib=%b required 0/0/0/1",
                     rq.size(), rd_count, wr_count, init_calib_complete);
        end
        xfer(0, 1, 3'd0, '0, 64'h55, '0, 0);
        tick();
        n_cmp++;
        if (proto_err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_no_end: proto_err got %b required 1", proto_err);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_data_after_cmd();
        test_backpressure();
        test_mask_alias();
        test_errors_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
